tt_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a 4-input combinational function unit (inputs a,b,c,d; output f) in-circuit. On start it drives all 2**N_IN input vectors in ascending order, waits a settle time, and captures f into a truth-table register. It then compares the captured table against a caller-supplied expected minterm mask. It sits between a host/control FSM and the function unit, and replaces hand-written exhaustive stimulus with a reusable hardware checker.

---
 rtl/tt_sweep_ctrl_pkg.sv | 14 +
 rtl/tt_sweep_ctrl_settle_timer.sv | 27 ++
 rtl/tt_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared types and defaults for the truth-table sweep controller.
package tt_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } sweep_state_e;

  localparam int unsigned NInDefault    = 4;
  localparam int unsigned SettleDefault = 1;

endpackage

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// Settle timer: cleared by load, counts while enabled, flags the last settle cycle.
module tt_sweep_ctrl_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Asserted during the SETTLE-th enabled cycle after a load.
  assign expire_o = en_i && (cnt_q == 4'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive in-circuit sweep of a combinational function unit, capturing its truth table
// and comparing it against a latched expected minterm mask.
module tt_sweep_ctrl
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_IN   = NInDefault,
  parameter int unsigned SETTLE = SettleDefault,
  localparam int unsigned V     = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [V-1:0]    expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic [V-1:0]    tt,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_vld
);

  localparam int unsigned IdxW = N_IN + 1;

  sweep_state_e    state_q;
  logic [IdxW-1:0] idx_q;
  logic [V-1:0]    exp_q;
  logic [N_IN-1:0] idx_lo;
  logic [IdxW-1:0] cnt_nxt;
  logic            miss;
  logic            last;
  logic            timer_load;
  logic            timer_en;
  logic            settle_expire;

  assign idx_lo     = idx_q[N_IN-1:0];
  assign dut_in     = idx_lo;
  assign miss       = dut_f ^ exp_q[idx_lo];
  assign last       = (idx_q == IdxW'(V - 1));
  assign cnt_nxt    = mismatch_cnt + IdxW'(miss);
  assign timer_en   = (state_q == StDrive);
  assign timer_load = ((state_q == StIdle) && start) ||
                      ((state_q == StSample) && !abort && !last);

  tt_sweep_ctrl_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .expire_o (settle_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      exp_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tt             <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            exp_q          <= expected;
            tt             <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
            idx_q          <= '0;
            busy           <= 1'b1;
            state_q        <= StDrive;
          end
        end
        StDrive: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (settle_expire) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          // Abort wins over the capture of the vector currently on dut_in.
          if (abort) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            tt[idx_lo]   <= dut_f;
            mismatch_cnt <= cnt_nxt;
            if (miss && !first_fail_vld) begin
              first_fail_idx <= idx_lo;
              first_fail_vld <= 1'b1;
            end
            if (last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (cnt_nxt == '0);
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StDrive;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) checked every cycle
// against a timeline model, plus directed literal expectations.
module tb_tt_sweep_ctrl;

  localparam int NV = 16;

  logic       clk = 1'b0;
  logic       rst_a   [2];
  logic       start_a [2];
  logic       abort_a [2];
  logic [15:0] exp_a  [2];
  logic [3:0] din     [2];
  logic       f_a     [2];
  logic       busy_a  [2];
  logic       done_a  [2];
  logic [15:0] tt_a   [2];
  logic       pass_a  [2];
  logic [4:0] cnt_a   [2];
  logic [3:0] ffi_a   [2];
  logic       ffv_a   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_seen [2] = '{0, 0};

  // Model state: one record of the latest accepted sweep per instance.
  bit        run   [2] = '{0, 0};
  int        e0    [2] = '{0, 0};
  int        ka    [2] = '{-1, -1};
  logic [15:0] mexp [2];
  int        per   [2] = '{2, 4};

  always #5 clk = ~clk;

  function automatic logic fn(input logic [3:0] v);
    return (v[3] & v[2]) | (~v[1] & v[0]);
  endfunction

  assign f_a[0] = fn(din[0]);
  assign f_a[1] = fn(din[1]);

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_a[0]), .start(start_a[0]), .abort(abort_a[0]),
    .expected(exp_a[0]), .dut_in(din[0]), .dut_f(f_a[0]), .busy(busy_a[0]),
    .done(done_a[0]), .tt(tt_a[0]), .pass(pass_a[0]), .mismatch_cnt(cnt_a[0]),
    .first_fail_idx(ffi_a[0]), .first_fail_vld(ffv_a[0])
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_a[1]), .start(start_a[1]), .abort(abort_a[1]),
    .expected(exp_a[1]), .dut_in(din[1]), .dut_f(f_a[1]), .busy(busy_a[1]),
    .done(done_a[1]), .tt(tt_a[1]), .pass(pass_a[1]), .mismatch_cnt(cnt_a[1]),
    .first_fail_idx(ffi_a[1]), .first_fail_vld(ffv_a[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, req, $time);
    end
  endtask

  // k = edges since the start was sampled; each vector occupies per[d] edges.
  function automatic bit m_busy(input int d, input int at);
    int k;
    if (!run[d]) return 1'b0;
    k = at - e0[d];
    return (ka[d] < 0) ? (k < NV * per[d]) : (k < ka[d]);
  endfunction

  function automatic bit m_idle(input int d, input int at);
    int k;
    if (!run[d]) return 1'b1;
    k = at - e0[d];
    return (ka[d] < 0) ? (k > NV * per[d]) : (k >= ka[d]);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_a[d]) begin
        run[d] = 1'b0;
      end else if (m_idle(d, cyc)) begin
        if (start_a[d]) begin
          run[d]  = 1'b1;
          e0[d]   = cyc + 1;
          ka[d]   = -1;
          mexp[d] = exp_a[d];
        end
      end else if (m_busy(d, cyc) && abort_a[d]) begin
        ka[d] = cyc + 1 - e0[d];
      end
    end
    cyc = cyc + 1;
  end

  task automatic model_out(input int d, output logic [3:0] e_in, output logic e_busy,
                           output logic e_done, output logic [15:0] e_tt,
                           output logic e_pass, output logic [4:0] e_cnt,
                           output logic [3:0] e_ffi, output logic e_ffv);
    int k, kk, ncap;
    e_in = '0; e_busy = 1'b0; e_done = 1'b0; e_tt = '0;
    e_pass = 1'b0; e_cnt = '0; e_ffi = '0; e_ffv = 1'b0;
    if (!rst_a[d] || !run[d]) return;
    k    = cyc - e0[d];
    kk   = (ka[d] >= 0 && k >= ka[d]) ? ka[d] - 1 : k;
    ncap = kk / per[d];
    if (ncap > NV) ncap = NV;
    e_in   = (kk >= NV * per[d]) ? 4'd15 : 4'(kk / per[d]);
    e_busy = m_busy(d, cyc);
    e_done = (ka[d] < 0) && (k == NV * per[d]);
    for (int i = 0; i < ncap; i++) begin
      e_tt[i] = fn(4'(i));
      if (e_tt[i] != mexp[d][i]) begin
        e_cnt = e_cnt + 5'd1;
        if (!e_ffv) begin
          e_ffi = 4'(i);
          e_ffv = 1'b1;
        end
      end
    end
    e_pass = (ka[d] < 0) && (k >= NV * per[d]) && (e_cnt == 5'd0);
  endtask

  always @(negedge clk) begin
    logic [3:0] e_in, e_ffi;
    logic e_busy, e_done, e_pass, e_ffv;
    logic [15:0] e_tt;
    logic [4:0] e_cnt;
    for (int d = 0; d < 2; d++) begin
      model_out(d, e_in, e_busy, e_done, e_tt, e_pass, e_cnt, e_ffi, e_ffv);
      chk("dut_in", d, 32'(din[d]), 32'(e_in));
      chk("busy", d, 32'(busy_a[d]), 32'(e_busy));
      chk("done", d, 32'(done_a[d]), 32'(e_done));
      chk("tt", d, 32'(tt_a[d]), 32'(e_tt));
      chk("pass", d, 32'(pass_a[d]), 32'(e_pass));
      chk("mismatch_cnt", d, 32'(cnt_a[d]), 32'(e_cnt));
      chk("first_fail_idx", d, 32'(ffi_a[d]), 32'(e_ffi));
      chk("first_fail_vld", d, 32'(ffv_a[d]), 32'(e_ffv));
      if (done_a[d] === 1'b1) done_seen[d]++;
    end
  end

  task automatic pulse_start(input int d, input logic [15:0] ex);
    @(posedge clk); #1;
    start_a[d] = 1'b1;
    exp_a[d]   = ex;
    @(posedge clk); #1;
    start_a[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int limit, output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (done_a[d] === 1'b1) break;
      if (lat >= limit) begin
        total++; bad++;
        $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, limit);
        break;
      end
    end
  endtask

  task automatic wait_din(input int d, input logic [3:0] v, input int limit);
    int n = 0;
    while (din[d] !== v) begin
      @(posedge clk); #1;
      n++;
      if (n >= limit) begin
        total++; bad++;
        $display("FAIL din_timeout dut%0d: dut_in never reached %0d", d, v);
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag, input int d);
    chk({tag, "_dut_in"}, d, 32'(din[d]), 32'd0);
    chk({tag, "_busy"}, d, 32'(busy_a[d]), 32'd0);
    chk({tag, "_done"}, d, 32'(done_a[d]), 32'd0);
    chk({tag, "_tt"}, d, 32'(tt_a[d]), 32'd0);
    chk({tag, "_pass"}, d, 32'(pass_a[d]), 32'd0);
    chk({tag, "_cnt"}, d, 32'(cnt_a[d]), 32'd0);
    chk({tag, "_ffi"}, d, 32'(ffi_a[d]), 32'd0);
    chk({tag, "_ffv"}, d, 32'(ffv_a[d]), 32'd0);
  endtask

  initial begin
    int lat, nd, ds;
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1'b0; start_a[d] = 1'b0; abort_a[d] = 1'b0; exp_a[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
    rst_a[0] = 1'b1;
    rst_a[1] = 1'b1;

    // 1: matching expectation
    pulse_start(0, 16'hF222);
    wait_done(0, 100, lat);
    chk("t1_latency", 0, 32'(lat), 32'd32);
    chk("t1_tt", 0, 32'(tt_a[0]), 32'hF222);
    chk("t1_pass", 0, 32'(pass_a[0]), 32'd1);
    chk("t1_cnt", 0, 32'(cnt_a[0]), 32'd0);
    chk("t1_ffv", 0, 32'(ffv_a[0]), 32'd0);

    // 2: single differing minterm at index 0
    pulse_start(0, 16'hF223);
    wait_done(0, 100, lat);
    chk("t2_tt", 0, 32'(tt_a[0]), 32'hF222);
    chk("t2_pass", 0, 32'(pass_a[0]), 32'd0);
    chk("t2_cnt", 0, 32'(cnt_a[0]), 32'd1);
    chk("t2_ffi", 0, 32'(ffi_a[0]), 32'd0);
    chk("t2_ffv", 0, 32'(ffv_a[0]), 32'd1);

    // 3: every minterm inverted
    pulse_start(0, 16'h0DDD);
    wait_done(0, 100, lat);
    chk("t3_cnt", 0, 32'(cnt_a[0]), 32'd16);
    chk("t3_ffi", 0, 32'(ffi_a[0]), 32'd0);
    chk("t3_pass", 0, 32'(pass_a[0]), 32'd0);

    // 4: start held high, expected changed after the first start was latched
    @(posedge clk); #1;
    start_a[0] = 1'b1;
    exp_a[0]   = 16'hF222;
    nd = 0;
    for (int t = 1; t <= 110; t++) begin
      @(posedge clk); #1;
      if (t == 5) exp_a[0] = 16'h0000;
      if (done_a[0] === 1'b1) begin
        if (nd == 0) chk("t4_first_pass", 0, 32'(pass_a[0]), 32'd1);
        nd++;
      end
    end
    start_a[0] = 1'b0;
    chk("t4_done_count", 0, 32'(nd), 32'd3);
    wait_done(0, 100, lat);

    // 5: abort while vector 7 is on dut_in, then a clean run
    pulse_start(0, 16'hF222);
    wait_din(0, 4'd7, 60);
    ds = done_seen[0];
    abort_a[0] = 1'b1;
    @(posedge clk); #1;
    abort_a[0] = 1'b0;
    chk("t5_busy", 0, 32'(busy_a[0]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", 0, 32'(done_seen[0] - ds), 32'd0);
    chk("t5_tt", 0, 32'(tt_a[0]), 32'h0022);
    chk("t5_pass", 0, 32'(pass_a[0]), 32'd0);
    chk("t5_din", 0, 32'(din[0]), 32'd7);
    pulse_start(0, 16'hF222);
    wait_done(0, 100, lat);
    chk("t5_rerun_tt", 0, 32'(tt_a[0]), 32'hF222);
    chk("t5_rerun_pass", 0, 32'(pass_a[0]), 32'd1);

    // 6: SETTLE=3 instance, async reset mid-sweep, then a full run
    pulse_start(1, 16'hF222);
    wait_din(1, 4'd9, 200);
    #2;
    rst_a[1] = 1'b0;
    #1;
    chk_all_zero("t6_async", 1);
    @(posedge clk); #1;
    rst_a[1] = 1'b1;
    pulse_start(1, 16'hF222);
    wait_done(1, 200, lat);
    chk("t6_latency", 1, 32'(lat), 32'd64);
    chk("t6_tt", 1, 32'(tt_a[1]), 32'hF222);
    chk("t6_pass", 1, 32'(pass_a[1]), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
